// File: rtl/fifo_buffer.sv
// ============================================================================
// Module   : fifo_buffer
// Purpose  : Synchronous FIFO with integrated RAM, occupancy count, status
//            flags and sticky overflow/underflow error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_buffer #(
    parameter int DATA_SIZE = 4,
    parameter int ADDR_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic [ADDR_SIZE:0]   almost_full_thr,
    input  logic [ADDR_SIZE:0]   almost_empty_thr,
    input  logic                 err_clr,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int                   DEPTH       = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0]   c_DEPTH     = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0]   c_CNT_ONE   = (ADDR_SIZE + 1)'(1);
    localparam logic [ADDR_SIZE-1:0] c_PTR_ONE   = ADDR_SIZE'(1);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic w_full, w_empty, w_rd_acc, w_wr_acc;

    assign w_full   = (count_q == c_DEPTH);
    assign w_empty  = (count_q == '0);
    assign w_rd_acc = read & ~w_empty;
    // A full FIFO still takes a write when a read frees the slot on the same edge.
    assign w_wr_acc = write & (~w_full | w_rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            data_d   = r_mem[rd_ptr_q];
            valid_d  = 1'b1;
        end

        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase

        // A fresh error in the clearing cycle keeps the flag set.
        ovf_d = (write & ~w_wr_acc) | (ovf_q & ~err_clr);
        unf_d = (read  & ~w_rd_acc) | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign count        = count_q;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (count_q >= almost_full_thr);
    assign almost_empty = (count_q <= almost_empty_thr);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

`default_nettype wire
